// File: rtl/bus_arbiter_pkg.sv
// Shared types and the round-robin pick function for the memory-port arbiter
// and the DMA blocks that reuse its picker.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_DATA, DONE} state_t;

  localparam int BURST_W_DEF = 4;
  localparam int MAX_CH      = 8;

  // One-hot grant for the first set bit of req at or after ptr, wrapping at n.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [2:0]        ptr,
                                                input int                n);
    logic [2:0] c;
    rr_pick = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      c = 3'((int'(ptr) + i) % n);
      if (i < n && rr_pick == '0 && req[c]) rr_pick[c] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Client-channel and memory-port signals of the arbiter, grouped for port passing.
interface bus_arbiter_if #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) ();
  logic [NUM_CH-1:0]              ch_req;
  logic [NUM_CH-1:0]              ch_write;
  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr;
  logic [NUM_CH-1:0][BURST_W-1:0] ch_burst;
  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata;
  logic [NUM_CH-1:0]              ch_grant;
  logic [NUM_CH-1:0]              ch_wnext;
  logic [NUM_CH-1:0]              ch_rvalid;
  logic [DATA_W-1:0]              ch_rdata;
  logic [NUM_CH-1:0]              ch_done;
  logic                           mem_read;
  logic                           mem_write;
  logic [ADDR_W-1:0]              mem_addr;
  logic [BURST_W-1:0]             mem_burst;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_wait;
  logic                           mem_rvalid;
  logic [DATA_W-1:0]              mem_rdata;

  modport master (
    input  ch_req, ch_write, ch_addr, ch_burst, ch_wdata, mem_wait, mem_rvalid, mem_rdata,
    output ch_grant, ch_wnext, ch_rvalid, ch_rdata, ch_done,
           mem_read, mem_write, mem_addr, mem_burst, mem_wdata
  );

  modport slave (
    output ch_req, ch_write, ch_addr, ch_burst, ch_wdata, mem_wait, mem_rvalid, mem_rdata,
    input  ch_grant, ch_wnext, ch_rvalid, ch_rdata, ch_done,
           mem_read, mem_write, mem_addr, mem_burst, mem_wdata
  );
endinterface

// File: rtl/bus_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: one-hot grant plus its index.
module rr_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);
  logic [MAX_CH-1:0] grant_all;

  assign grant_all = rr_pick(MAX_CH'(req), 3'(ptr), NUM_CH);
  assign grant     = grant_all[NUM_CH-1:0];
  assign any       = |req;

  always_comb begin
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (grant_all[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter of NUM_CH burst clients onto one Avalon-style memory port.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 32,
  parameter int BURST_W = BURST_W_DEF
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_CH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d, cnt_q, cnt_d;

  logic [NUM_CH-1:0]  pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [BURST_W-1:0] pick_burst;
  logic               busy, wr_beat, rd_beat;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req   (bus.ch_req),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A zero beat count is a single-beat transfer.
  assign pick_burst = (bus.ch_burst[pick_idx] == '0) ? BURST_W'(1) : bus.ch_burst[pick_idx];

  assign busy    = state_q inside {WR, RD_CMD, RD_DATA};
  assign wr_beat = (state_q == WR) && !bus.mem_wait;
  assign rd_beat = (state_q == RD_DATA) && bus.mem_rvalid;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          grant_d = pick_grant;
          addr_d  = bus.ch_addr[pick_idx];
          burst_d = pick_burst;
          cnt_d   = pick_burst;
          state_d = bus.ch_write[pick_idx] ? WR : RD_CMD;
        end
      end
      WR: begin
        if (wr_beat) begin
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) state_d = DONE;
        end
      end
      RD_CMD: begin
        if (!bus.mem_wait) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rd_beat) begin
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = (owner_q == IDX_W'(NUM_CH - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any burst in flight; the memory controller copes with that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.ch_grant  = busy ? grant_q : '0;
  assign bus.ch_wnext  = wr_beat ? grant_q : '0;
  assign bus.ch_rvalid = rd_beat ? grant_q : '0;
  assign bus.ch_done   = (state_q == DONE) ? grant_q : '0;
  assign bus.ch_rdata  = bus.mem_rdata;
  assign bus.mem_write = (state_q == WR);
  assign bus.mem_read  = (state_q == RD_CMD);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_burst = burst_q;
  assign bus.mem_wdata = (state_q == WR) ? bus.ch_wdata[owner_q] : '0;
endmodule
